// File: rtl/ram_bus_master_pkg.sv
// Shared definitions for the RAM bus master: default widths, RW encodings, FSM state type.
package ram_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        TURN
    } bus_state_t;

endpackage

// File: rtl/ram_data_iobuf.sv
// Tri-state driver for the RAM data bus; keeps all Z handling out of the bus master FSM.
module ram_data_iobuf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_drive_en,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    inout  logic [DATA_W-1:0] io_data
);

    assign io_data = i_drive_en ? i_wdata : {DATA_W{1'bz}};
    assign o_rdata = io_data;

endmodule

// File: rtl/ram_bus_master.sv
// Valid/ready client to single-port RAM bus initiator with registered read response.
// Optional RAM_BUS_MASTER_TURNAROUND_EN adds a dead TURN cycle after each read capture.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              Busy,
    output logic [ADDR_W-1:0] Address,
    inout  logic [DATA_W-1:0] Data,
    output logic              RW,
    output logic              En
);

    bus_state_t        r_state;
    bus_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_bus_rdata;
    logic              w_idle_ready;
    logic              w_accept;
    logic              w_en;
    logic              w_rw;
    logic              w_drive;

    always_comb begin
        w_next       = r_state;
        w_idle_ready = 1'b0;
        w_en         = 1'b0;
        w_rw         = RW_WRITE;
        w_drive      = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle_ready = !r_rsp_valid;
                if (ReqValid && w_idle_ready) begin
                    w_next = ReqWrite ? WRITE : READ;
                end
            end
            WRITE: begin
                w_en    = 1'b1;
                w_drive = 1'b1;
                w_next  = IDLE;
            end
            READ: begin
                w_en   = 1'b1;
                w_rw   = RW_READ;
                w_next = CAPTURE;
            end
            CAPTURE: begin
                w_rw = RW_READ;
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
                w_next = TURN;
`else
                w_next = IDLE;
`endif
            end
            TURN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Ready is masked by rst so nothing is accepted on a reset edge.
    assign ReqReady = w_idle_ready && !rst;
    assign w_accept = ReqValid && ReqReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= ReqAddr;
            end
            if (r_state == CAPTURE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_bus_rdata;
            end else if (r_rsp_valid && RspReady) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Write data is pure datapath; it is only visible on the bus in WRITE.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wdata <= ReqWData;
        end
    end

    ram_data_iobuf #(
        .DATA_W(DATA_W)
    ) u_iobuf (
        .i_drive_en(w_drive),
        .i_wdata   (r_wdata),
        .o_rdata   (w_bus_rdata),
        .io_data   (Data)
    );

    assign Address  = r_addr;
    assign RW       = w_rw;
    assign En       = w_en;
    assign RspValid = r_rsp_valid;
    assign RspData  = r_rsp_data;
    assign Busy     = (r_state != IDLE) || r_rsp_valid;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural 1 KB synchronous RAM on the bus.
`timescale 1ns/1ps
module tb_ram_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       ReqValid;
    logic       ReqReady;
    logic       ReqWrite;
    logic [9:0] ReqAddr;
    logic [7:0] ReqWData;
    logic       RspValid;
    logic       RspReady;
    logic [7:0] RspData;
    logic       Busy;
    logic [9:0] Address;
    wire  [7:0] Data;
    logic       RW;
    logic       En;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:1023];
    logic [7:0] ram_q;
    logic       tb_drv;
    logic [7:0] tb_val;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .Busy(Busy), .Address(Address), .Data(Data), .RW(RW), .En(En)
    );

    // RAM: drives its output register whenever RW is low.
    assign Data = (RW == 1'b0) ? ram_q : 8'bz;
    assign Data = tb_drv ? tb_val : 8'bz;

    always @(posedge clk) begin
        if (En) begin
            if (RW) mem[Address] <= Data;
            else    ram_q <= mem[Address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [9:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWData = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (ReqReady) ok = 1'b1;
            tick();
        end
        ReqValid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_timeout: ReqReady=%b required 1 within 50 cycles", ReqReady);
        end
    endtask

    task automatic take_rsp(output logic [7:0] d);
        for (int i = 0; i < 50 && !RspValid; i++) tick();
        n_checks++;
        if (RspValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: RspValid=%b required 1 within 50 cycles", RspValid);
        end
        d = RspData;
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({ReqReady, RspValid, RspData, Busy, Address, RW, En} !== {1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b rv=%b rd=%h busy=%b addr=%h rw=%b en=%b required 0 0 00 0 000 1 0",
                     ReqReady, RspValid, RspData, Busy, Address, RW, En);
        end
        rst = 1'b0;
        tick();
        issue(1'b0, 10'h155, 8'hFF);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({En, RW, RspValid, ReqReady, Busy} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_midread_bus: en=%b rw=%b rv=%b rdy=%b busy=%b required 0 1 0 0 0",
                     En, RW, RspValid, ReqReady, Busy);
        end
        tb_val = 8'h00; tb_drv = 1'b1;
        #1;
        n_checks++;
        if (Data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_released: Data=%h required 00 (bench probe)", Data);
        end
        tb_drv = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ReqReady=%b required 1", ReqReady);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (RspValid !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_response: RspValid=%b Busy=%b required 0 0", RspValid, Busy);
        end
    endtask

    task automatic test_write_read();
        issue(1'b1, 10'h3FF, 8'hA5);
        issue(1'b0, 10'h3FF, 8'h00);
        n_checks++;
        if ({En, RW, RspValid, Address} !== {1'b1, 1'b0, 1'b0, 10'h3FF}) begin
            n_fail++;
            $display("FAIL wr_rd_read_cycle: en=%b rw=%b rv=%b addr=%h required 1 0 0 3ff", En, RW, RspValid, Address);
        end
        tick();
        n_checks++;
        if ({En, RW, RspValid} !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_rd_capture_cycle: en=%b rw=%b rv=%b required 0 0 0", En, RW, RspValid);
        end
        tick();
        // Accept edge counts as edge 1; RspValid is visible after edge 3.
        n_checks++;
        if (RspValid !== 1'b1 || RspData !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_rd_latency: rv=%b data=%h required 1 a5", RspValid, RspData);
        end
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        n_checks++;
        if (RspValid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_rsp_clear: RspValid=%b required 0", RspValid);
        end
    endtask

    task automatic test_addr_extremes();
        logic [7:0] d;
        issue(1'b1, 10'h000, 8'h01);
        issue(1'b1, 10'h3FF, 8'h80);
        issue(1'b0, 10'h000, 8'h00);
        take_rsp(d);
        n_checks++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL addr_low: data=%h required 01", d);
        end
        issue(1'b0, 10'h3FF, 8'h00);
        take_rsp(d);
        n_checks++;
        if (d !== 8'h80) begin
            n_fail++;
            $display("FAIL addr_high: data=%h required 80", d);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        issue(1'b1, 10'h123, 8'h5C);
        issue(1'b0, 10'h123, 8'h00);
        for (int i = 0; i < 20 && !RspValid; i++) tick();
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 10'h124; ReqWData = 8'h77;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({RspValid, RspData, ReqReady, Busy, En} !== {1'b1, 8'h5C, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: rv=%b data=%h rdy=%b busy=%b en=%b required 1 5c 0 1 0",
                         i, RspValid, RspData, ReqReady, Busy, En);
            end
            tick();
        end
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        n_checks++;
        if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rv=%b rdy=%b required 0 1", RspValid, ReqReady);
        end
        tick();
        ReqValid = 1'b0;
        n_checks++;
        if ({En, RW, Address, Data} !== {1'b1, 1'b1, 10'h124, 8'h77}) begin
            n_fail++;
            $display("FAIL bp_queued_write: en=%b rw=%b addr=%h data=%h required 1 1 124 77", En, RW, Address, Data);
        end
        tick();
        issue(1'b0, 10'h124, 8'h00);
        take_rsp(d);
        n_checks++;
        if (d !== 8'h77) begin
            n_fail++;
            $display("FAIL bp_readback: data=%h required 77", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int  phase;
        int  gap;
        bit  seen_rd;
        bit  done;
        bit  acc;
        issue(1'b1, 10'h020, 8'h00);
        phase = 0; gap = 0; seen_rd = 1'b0; done = 1'b0;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 10'h020; ReqWData = 8'hC3;
        RspReady = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            acc = ReqValid && ReqReady;
            if (RW == 1'b0) begin
                seen_rd = 1'b1;
                gap = 0;
                n_checks++;
                if (En == 1'b0 && Data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL b2b_capture_data: Data=%h required 00", Data);
                end else if (En == 1'b1 && Data !== ram_q) begin
                    n_fail++;
                    $display("FAIL b2b_read_data: Data=%h required %h", Data, ram_q);
                end
            end else if (En == 1'b1) begin
                if (seen_rd) begin
                    done = 1'b1;
                    n_checks++;
                    if (Data !== 8'h3C || Address !== 10'h010 || gap < 1) begin
                        n_fail++;
                        $display("FAIL b2b_write: data=%h addr=%h gap=%0d required 3c 010 >=1", Data, Address, gap);
                    end
                end
            end else if (seen_rd) begin
                gap++;
            end
            tick();
            if (acc) begin
                if (phase == 0) begin
                    ReqWrite = 1'b1; ReqAddr = 10'h010; ReqWData = 8'h3C;
                    phase = 1;
                end else begin
                    ReqValid = 1'b0;
                    phase = 2;
                end
            end
        end
        ReqValid = 1'b0;
        RspReady = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL b2b_timeout: write after read seen=%b required 1", done);
        end
        issue(1'b0, 10'h010, 8'h00);
        take_rsp(d);
        n_checks++;
        if (d !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_readback: data=%h required 3c", d);
        end
    endtask

    task automatic test_stream();
        logic [9:0] a [16];
        logic [7:0] w [16];
        logic [7:0] d;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            a[i] = 10'($urandom_range(1023, 0));
            w[i] = 8'($urandom_range(255, 0));
            issue(1'b1, a[i], w[i]);
        end
        for (int j = 0; j < 16; j++) begin
            exp = w[j];
            for (int k = 0; k < 16; k++) if (a[k] == a[j]) exp = w[k];
            issue(1'b0, a[j], 8'h00);
            take_rsp(d);
            n_checks++;
            if (d !== exp) begin
                n_fail++;
                $display("FAIL stream_read %0d addr %h: data=%h required %h", j, a[j], d, exp);
            end
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_busy: Busy=%b required 0", Busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
    end

    initial begin
        rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
        RspReady = 1'b0; tb_drv = 1'b0; tb_val = '0;
        test_reset();
        test_write_read();
        test_addr_extremes();
        test_backpressure();
        test_back_to_back();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
